// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and checker.
// Both sides of the loop use lfsr_next so that they can never disagree on the
// polynomial.
package lfsr_pkg;

  localparam int LFSR_W      = 8;
  localparam int LFSR_PERIOD = 255;

  // Feedback taps: bits 0, 2, 3 and 4 feed the new MSB.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;

  // Checker states: hunting for a seed, syncing, locked and slipping.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } state_t;

  // Right-shifting Fibonacci step. All-zero is a fixed point and never occurs
  // in a healthy stream.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single-step LFSR advance. The checker instantiates one copy
// for the received word and one for its own prediction.
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] next_o
);

  // Advance the input word by one LFSR step.
  always_comb begin
    next_o = lfsr_next(state_i);
  end

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR pattern stream.
// It synchronises to the incoming sequence, then flywheels its own prediction.
// While locked it counts mispredictions and flags every full period.
// Lock is dropped after a run of consecutive misses.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clr,
  output logic              locked,
  output logic              mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              period_pulse,
  output logic [LFSR_W-1:0] expect_word
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);
  localparam int POS_W  = $clog2(LFSR_PERIOD);

  localparam logic [GOOD_W-1:0] GOOD_TARGET = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_TARGET  = BAD_W'(LOSS_CNT);
  localparam logic [POS_W-1:0]  POS_LAST    = POS_W'(LFSR_PERIOD - 1);

  state_t              state_q, state_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [LFSR_W-1:0]   ref_q, ref_d;
  logic [LFSR_W-1:0]   expect_q, expect_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                locked_q, locked_d;
  logic                mismatch_q, mismatch_d;
  logic                period_q, period_d;

  logic [LFSR_W-1:0]   data_next;
  logic [LFSR_W-1:0]   expect_next;
  logic                data_zero;
  logic                data_match;
  logic [GOOD_W-1:0]   good_inc;
  logic [BAD_W-1:0]    bad_inc;
  logic                pos_wrap;

  // Successor of the received word, used when (re)seeding the prediction.
  lfsr_step u_step_data (
    .state_i (in_data),
    .next_o  (data_next)
  );

  // Successor of the current prediction, used for flywheeling once locked.
  lfsr_step u_step_expect (
    .state_i (expect_q),
    .next_o  (expect_next)
  );

  // Per-sample decode shared by the next-state and datapath logic.
  always_comb begin
    data_zero  = (in_data == '0);
    data_match = (in_data == expect_q);
    good_inc   = good_q + GOOD_W'(1);
    bad_inc    = bad_q + BAD_W'(1);
    pos_wrap   = (pos_q == POS_LAST);
  end

  // State register plus all counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= HUNT;
      good_q     <= '0;
      bad_q      <= '0;
      pos_q      <= '0;
      ref_q      <= '0;
      expect_q   <= '0;
      err_q      <= '0;
      locked_q   <= 1'b0;
      mismatch_q <= 1'b0;
      period_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      pos_q      <= pos_d;
      ref_q      <= ref_d;
      expect_q   <= expect_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      mismatch_q <= mismatch_d;
      period_q   <= period_d;
    end
  end

  // Next-state logic: only a valid sample can move the FSM.
  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (!data_zero) begin
            state_d = SYNC;
          end
        end
        SYNC: begin
          if (data_match) begin
            if (good_inc == GOOD_TARGET) begin
              state_d = LOCKED;
            end
          end else if (data_zero) begin
            state_d = HUNT;
          end
        end
        LOCKED: begin
          if (!data_match) begin
            state_d = (LOSS_CNT == 1) ? HUNT : SLIP;
          end
        end
        SLIP: begin
          if (data_match) begin
            state_d = LOCKED;
          end else if (bad_inc == BAD_TARGET) begin
            state_d = HUNT;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Datapath and output logic: prediction, run counters, period tracking, errors.
  always_comb begin
    good_d     = good_q;
    bad_d      = bad_q;
    pos_d      = pos_q;
    ref_d      = ref_q;
    expect_d   = expect_q;
    err_d      = err_q;
    mismatch_d = 1'b0;
    period_d   = 1'b0;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (!data_zero) begin
            expect_d = data_next;
            good_d   = '0;
          end
        end
        SYNC: begin
          if (data_match) begin
            good_d   = good_inc;
            expect_d = data_next;
            if (good_inc == GOOD_TARGET) begin
              ref_d = in_data;
              pos_d = '0;
            end
          end else if (!data_zero) begin
            expect_d = data_next;
            good_d   = '0;
          end
        end
        LOCKED, SLIP: begin
          expect_d = expect_next;
          pos_d    = pos_wrap ? '0 : pos_q + POS_W'(1);
          period_d = pos_wrap;
          if (data_match) begin
            bad_d = '0;
          end else begin
            mismatch_d = 1'b1;
            bad_d      = (state_q == LOCKED) ? BAD_W'(1) : bad_inc;
            if (err_q != '1) begin
              err_d = err_q + ERR_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end

    if (clr) begin
      err_d = '0;
    end

    locked_d = (state_d == LOCKED) || (state_d == SLIP);
  end

  // Drive ports straight from their flops.
  always_comb begin
    locked       = locked_q;
    mismatch     = mismatch_q;
    err_cnt      = err_q;
    period_pulse = period_q;
    expect_word  = expect_q;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker.
// A default instance and an ERR_W=2 instance share one input stream.
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clr;

  logic        locked;
  logic        mismatch;
  logic [15:0] err_cnt;
  logic        period_pulse;
  logic [7:0]  expect_word;

  logic        s_locked;
  logic        s_mismatch;
  logic [1:0]  s_err;
  logic        s_period;
  logic [7:0]  s_expect;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        c;
    logic        e_locked;
    logic        e_mis;
    logic [15:0] e_err;
    logic [1:0]  e_sat;
    logic        e_per;
    logic [7:0]  e_exp;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  lfsr_checker dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .clr          (clr),
    .locked       (locked),
    .mismatch     (mismatch),
    .err_cnt      (err_cnt),
    .period_pulse (period_pulse),
    .expect_word  (expect_word)
  );

  lfsr_checker #(.ERR_W(2)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .clr          (clr),
    .locked       (s_locked),
    .mismatch     (s_mismatch),
    .err_cnt      (s_err),
    .period_pulse (s_period),
    .expect_word  (s_expect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic c,
                              input logic lk, input logic mis, input logic [15:0] err,
                              input logic [1:0] sat, input logic per, input logic [7:0] ex);
    vec_t r;
    r.v = v; r.d = d; r.c = c;
    r.e_locked = lk; r.e_mis = mis; r.e_err = err;
    r.e_sat = sat; r.e_per = per; r.e_exp = ex;
    return r;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, got, want);
    end
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    e = exp_q.pop_front();
    cmp("locked", idx, 16'(locked), 16'(e.e_locked));
    cmp("mismatch", idx, 16'(mismatch), 16'(e.e_mis));
    cmp("err_cnt", idx, err_cnt, e.e_err);
    cmp("period_pulse", idx, 16'(period_pulse), 16'(e.e_per));
    cmp("expect", idx, 16'(expect_word), 16'(e.e_exp));
    cmp("sat_err_cnt", idx, 16'(s_err), 16'(e.e_sat));
    cmp("sat_locked", idx, 16'(s_locked), 16'(e.e_locked));
    cmp("sat_mismatch", idx, 16'(s_mismatch), 16'(e.e_mis));
    cmp("sat_period", idx, 16'(s_period), 16'(e.e_per));
    cmp("sat_expect", idx, 16'(s_expect), 16'(e.e_exp));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    in_valid = v.v;
    in_data  = v.d;
    clr      = v.c;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  task automatic checkReset(input int idx);
    cmp("rst_locked", idx, 16'(locked), 16'h0);
    cmp("rst_mismatch", idx, 16'(mismatch), 16'h0);
    cmp("rst_err_cnt", idx, err_cnt, 16'h0);
    cmp("rst_period", idx, 16'(period_pulse), 16'h0);
    cmp("rst_expect", idx, 16'(expect_word), 16'h0);
    cmp("rst_sat_err", idx, 16'(s_err), 16'h0);
  endtask

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] s;
    int idx;

    rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; clr = 1'b0;
    #2;
    checkReset(-1);
    @(negedge clk);
    rst = 1'b1;

    // Acquire, single error, clr against a miss, loss of lock.
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 16'd0, 2'd0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 16'd0, 2'd0, 0, 8'h80));
    tbl.push_back(mk(1, 8'h80, 0, 0, 0, 16'd0, 2'd0, 0, 8'h40));
    tbl.push_back(mk(0, 8'h55, 0, 0, 0, 16'd0, 2'd0, 0, 8'h40));
    tbl.push_back(mk(1, 8'h40, 0, 0, 0, 16'd0, 2'd0, 0, 8'h20));
    tbl.push_back(mk(1, 8'h20, 0, 0, 0, 16'd0, 2'd0, 0, 8'h10));
    tbl.push_back(mk(1, 8'h10, 0, 1, 0, 16'd0, 2'd0, 0, 8'h88));
    tbl.push_back(mk(1, 8'h88, 0, 1, 0, 16'd0, 2'd0, 0, 8'hC4));
    tbl.push_back(mk(1, 8'h00, 0, 1, 1, 16'd1, 2'd1, 0, 8'hE2));
    tbl.push_back(mk(1, 8'hE2, 0, 1, 0, 16'd1, 2'd1, 0, 8'h71));
    tbl.push_back(mk(0, 8'h33, 0, 1, 0, 16'd1, 2'd1, 0, 8'h71));
    tbl.push_back(mk(1, 8'h71, 0, 1, 0, 16'd1, 2'd1, 0, 8'h38));
    tbl.push_back(mk(1, 8'hFF, 1, 1, 1, 16'd0, 2'd0, 0, 8'h1C));
    tbl.push_back(mk(1, 8'h1C, 0, 1, 0, 16'd0, 2'd0, 0, 8'h8E));
    tbl.push_back(mk(1, 8'h00, 0, 1, 1, 16'd1, 2'd1, 0, 8'h47));
    tbl.push_back(mk(1, 8'h00, 0, 1, 1, 16'd2, 2'd2, 0, 8'h23));
    tbl.push_back(mk(1, 8'h00, 0, 0, 1, 16'd3, 2'd3, 0, 8'h91));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i], i);
    end

    // Relock on seed 0x01 and run one full period with an idle gap inside.
    s = 8'h01;
    idx = 100;
    for (int k = 0; k < 260; k++) begin
      if (k == 100) begin
        applyStimulus(mk(0, 8'hA5, 0, 1, 0, 16'd3, 2'd3, 0, s), idx);
        idx++;
      end
      applyStimulus(mk(1, s, 0, (k >= 4), 0, 16'd3, 2'd3, (k == 259), step8(s)), idx);
      idx++;
      s = step8(s);
    end

    // One more miss pushes the narrow counter past its ceiling.
    applyStimulus(mk(1, 8'h00, 0, 1, 1, 16'd4, 2'd3, 0, 8'hC4), 500);
    applyStimulus(mk(0, 8'h00, 1, 1, 0, 16'd0, 2'd0, 0, 8'hC4), 501);

    // Reset while locked takes effect without a clock edge.
    rst = 1'b0;
    #2;
    checkReset(502);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(mk(1, 8'h00, 0, 0, 0, 16'd0, 2'd0, 0, 8'h00), 503);

    in_valid = 1'b0;
    clr = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side checker for the board's 8-bit LFSR pattern stream. It accepts one full LFSR state word per valid cycle and synchronises to the sequence. Once synchronised, it flywheels its own prediction and counts mismatches. It drops lock after repeated misses. Status feeds the LEDs and the seven-segment digits, closing the loop against the switch-seeded LFSR generator.

## Interface
- `LOCK_CNT`, default 4: consecutive correct predictions required to declare lock (≥1).
- `LOSS_CNT`, default 3: consecutive mispredictions while locked that drop lock (≥1).
- `ERR_W`, default 16: width of the error counter.
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: `in_data` is a sample this cycle.
- `in_data`  in  8: received LFSR state word.
- `clr`  in  1: synchronous clear of `err_cnt`. Lock is not affected.
- `locked`  out  1: checker is in LOCKED or SLIP.
- `mismatch`  out  1: one-cycle pulse for each mispredicted sample while locked.
- `err_cnt`  out  ERR_W: saturating count of locked mismatches.
- `period_pulse`  out  1: one-cycle pulse each time the sequence returns to the word held at lock entry.
- `expect`  out  8: next predicted word.

## Operation
- Step function: next(s) = {s[0]^s[2]^s[3]^s[4], s[7:1]}. This is a maximal sequence with period 255; 0x00 is illegal.
- No state changes occur when `in_valid`=0.
- HUNT:
  - valid with nonzero data: expect←next(data), good←0, go to SYNC.
  - valid with 0x00: stay in HUNT.
- SYNC:
  - data==expect: good++, expect←next(data). When good reaches LOCK_CNT, go to LOCKED, set ref←data, pos←0.
  - mismatch with nonzero data: reseed expect←next(data), good←0, stay in SYNC.
  - mismatch with 0x00: go to HUNT.
  - No `mismatch` pulses and no `err_cnt` changes in this state.
- LOCKED:
  - match: expect←next(expect), bad←0.
  - mismatch: pulse `mismatch`, `err_cnt`++ (saturating at all-ones), expect←next(expect) (flywheel, never reseed from data), bad←1. Go to SLIP, or to HUNT directly if LOSS_CNT=1.
- SLIP:
  - match: return to LOCKED, bad←0.
  - mismatch: pulse `mismatch`, `err_cnt`++, bad++. When bad reaches LOSS_CNT, go to HUNT.
  - expect advances exactly as in LOCKED.
- Period tracking in LOCKED and SLIP:
  - pos counts accepted samples modulo 255.
  - `period_pulse` fires when pos wraps to 0, which happens on the sample where expect equals ref again.
  - On loss of lock, pos and ref freeze and pulses stop.
- `clr` together with a mismatch in the same cycle: `clr` wins and `err_cnt`=0. The mismatch pulse still fires.

## Timing
- All outputs are registered. `locked`, `mismatch`, `err_cnt`, `period_pulse` and `expect` reflect a sample on the cycle after it is accepted.
- Lock is declared LOCK_CNT+1 valid samples after the first nonzero word.
- Reset (asserted asynchronously, released synchronously):
  - state HUNT, `locked`=0, `mismatch`=0, `period_pulse`=0, `err_cnt`=0, `expect`=0x00.
  - good, bad and pos cleared.
- Reset mid-lock returns to HUNT immediately, without waiting for a clock.
- Back-to-back valid samples are accepted every cycle. There is no backpressure.

## Structure
- `lfsr_pkg` holds:
  - `LFSR_W`=8 and `LFSR_PERIOD`=255.
  - the tap constant and the state enum {HUNT, SYNC, LOCKED, SLIP}.
  - the next-state function, shared with the generator.
- Sub-module `lfsr_step`: combinational 8-bit next-state. It is instantiated once for the data path and once for the expect path.
- FSM, counters and period logic live in `lfsr_checker`.

## Test plan
- Reset: pulse `rst` low. All outputs match the reset values above, with no clock edge needed.
- Acquire: feed 0x01, 0x80, 0x40, 0x20, 0x10 (LOCK_CNT=4).
  - `locked` rises on the cycle after 0x10.
  - `expect`=0x88, `err_cnt`=0.
- Single error:
  - locked, feed 0x88, then 0x00 instead of 0xC4. Result: `mismatch` pulses once, `err_cnt`=1, SLIP.
  - feed 0xE2. Result: back to LOCKED, `locked` stays 1 throughout.
- Loss: locked, feed three consecutive wrong words. `err_cnt`+3, `locked` falls after the third.
- Period: lock on seed 0x01, then feed 255 further correct words. Exactly one `period_pulse` occurs, on the sample equal to ref.
- Corner cases:
  - `clr` coincident with a mismatch gives `err_cnt`=0.
  - 0x00 in HUNT stays in HUNT.
  - ERR_W=2 forced saturation holds at 3.
  - `in_valid` gaps mid-sequence do not break lock.
